// File: rtl/awg_pkg.sv
// Shared definitions for the multi-channel arbitrary waveform player:
// playback modes, sequencer states and read-path latency.
package awg_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_LOOP    = 2'd1;
  localparam logic [1:0] MODE_BURST   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PLAY
  } state_e;

  // Address issue -> registered RAM read -> output register.
  localparam int LAT = 2;

endpackage

// File: rtl/awg_chan_ram.sv
// Per-channel sample RAM: simple dual-port, read-first, registered read.
module awg_chan_ram #(
  parameter int DW = 14,
  parameter int AW = 14
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // NOTE: sample storage has no reset so it maps onto block RAM; only the
  // read register sees new data, and the non-blocking write makes a
  // same-address read in the same cycle return the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/awg_multi_player.sv
// Multi-channel waveform player: one shared sequencer drives every channel RAM
// so all lanes stay sample-aligned; window, loop/burst modes and trigger arming.
module awg_multi_player
  import awg_pkg::*;
#(
  parameter int                        NUM_CH         = 2,
  parameter int                        DAC_DATA_WIDTH = 14,
  parameter int                        ADDR_WIDTH     = 14,
  parameter int                        BURST_WIDTH    = 16,
  parameter logic [DAC_DATA_WIDTH-1:0] IDLE_CODE      = 14'h2000
) (
  input  logic                                        dac_clk,
  input  logic                                        rst,
  input  logic                                        wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [ADDR_WIDTH-1:0]                       wr_addr,
  input  logic [DAC_DATA_WIDTH-1:0]                   wr_data,
  input  logic [ADDR_WIDTH-1:0]                       cfg_start,
  input  logic [ADDR_WIDTH-1:0]                       cfg_end,
  input  logic [1:0]                                  cfg_mode,
  input  logic                                        cfg_trig_en,
  input  logic [BURST_WIDTH-1:0]                      cfg_burst,
  input  logic                                        start,
  input  logic                                        stop,
  input  logic                                        trig,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        dac_valid,
  output logic [NUM_CH*DAC_DATA_WIDTH-1:0]            dac_dat
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]            r_start, r_end, r_addr;
  logic [1:0]                       r_mode;
  logic [BURST_WIDTH-1:0]           r_burst_left;
  logic                             r_done, w_done_nxt;
  logic [LAT-1:0]                   r_vld;
  logic [NUM_CH*DAC_DATA_WIDTH-1:0] r_dat;
  logic [DAC_DATA_WIDTH-1:0]        w_ram_q [NUM_CH];
  logic                             w_accept, w_issue, w_last, w_more_passes;

  assign w_accept      = (r_state == IDLE) && start && !stop;
  assign w_issue       = (r_state == PLAY);
  assign w_last        = (r_addr == r_end);
  assign w_more_passes = (r_mode == MODE_LOOP) ||
                         ((r_mode == MODE_BURST) && (r_burst_left > BURST_WIDTH'(1)));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge dac_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = cfg_trig_en ? ARMED : PLAY;
      ARMED: if (trig)  w_state_nxt = PLAY;
      PLAY:  if (w_last && !w_more_passes) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
             end
      default: w_state_nxt = IDLE;
    endcase
    if (stop) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  // Shadow config is latched only on an accepted start; cfg_* is ignored while busy.
  always_ff @(posedge dac_clk or posedge rst) begin
    if (rst) begin
      r_start      <= '0;
      r_end        <= '0;
      r_mode       <= MODE_ONESHOT;
      r_burst_left <= '0;
      r_addr       <= '0;
    end else if (w_accept) begin
      r_start      <= cfg_start;
      r_end        <= cfg_end;
      r_mode       <= cfg_mode;
      r_burst_left <= (cfg_burst == '0) ? BURST_WIDTH'(1) : cfg_burst;
      r_addr       <= cfg_start;
    end else if (w_issue) begin
      if (w_last) begin
        r_addr <= r_start;
        if ((r_mode == MODE_BURST) && (r_burst_left > BURST_WIDTH'(1)))
          r_burst_left <= r_burst_left - BURST_WIDTH'(1);
      end else begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    awg_chan_ram #(
      .DW (DAC_DATA_WIDTH),
      .AW (ADDR_WIDTH)
    ) u_ram (
      .i_clk   (dac_clk),
      .i_we    (wr_en && (wr_ch == CH_W'(k))),
      .i_waddr (wr_addr),
      .i_wdata (wr_data),
      .i_raddr (r_addr),
      .o_rdata (w_ram_q[k])
    );
  end

  // Stop flushes in-flight samples so the lanes return to midscale on the next edge.
  always_ff @(posedge dac_clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_vld  <= '0;
      r_dat  <= {NUM_CH{IDLE_CODE}};
    end else begin
      r_done <= w_done_nxt;
      if (stop) begin
        r_vld <= '0;
        r_dat <= {NUM_CH{IDLE_CODE}};
      end else begin
        r_vld <= {r_vld[LAT-2:0], w_issue};
        for (int k = 0; k < NUM_CH; k++)
          r_dat[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] <= r_vld[0] ? w_ram_q[k] : IDLE_CODE;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dac_valid = r_vld[LAT-1];
  assign dac_dat   = r_dat;

endmodule
